// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator with an Avalon-MM register interface.
// Define STEP_POS_COUNTER_EN to add the signed POSITION register at word 0x06.
`timescale 1ns/1ps
module step_pulse_gen #(
    parameter int unsigned DIR_SETUP  = 4,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_write_data,
    input  logic        avs_read,
    output logic [31:0] avs_read_data,
    output logic        step_out,
    output logic        dir_out,
    output logic        irq
);
    localparam logic [7:0]  SETUP_LAST = 8'(DIR_SETUP - 1);
    localparam logic [31:0] MIN_PER    = 32'(MIN_PERIOD);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t      state;
    logic [7:0]  setup_cnt;
    logic [31:0] cnt;
    logic [31:0] sh_period;
    logic [31:0] sh_high;
    logic [31:0] sent_r;

    logic [31:0] period_r;
    logic [31:0] high_time_r;
    logic [31:0] pulse_num_r;
    logic        dir_r;
    logic        irq_en_r;
    logic        stop_req;
    logic        done_r;
    logic        aborted_r;
    logic        cfg_err_r;
    logic [31:0] pos_rd;

    logic wr_ctrl, wr_period, wr_high, wr_pnum, wr_status;
    logic start_cmd, stop_cmd, busy, pulsing;
    logic timing_ok, cfg_ok, start_ok;
    logic period_end, count_hit, move_end;
    logic done_set, aborted_set, cfg_err_set;
    logic [2:0] w1c;
    logic done_nxt, aborted_nxt, cfg_err_nxt, irq_en_nxt;

    assign wr_ctrl   = avs_write && (avs_address == 8'h00);
    assign wr_period = avs_write && (avs_address == 8'h01);
    assign wr_high   = avs_write && (avs_address == 8'h02);
    assign wr_pnum   = avs_write && (avs_address == 8'h03);
    assign wr_status = avs_write && (avs_address == 8'h04);

    assign start_cmd = wr_ctrl && avs_write_data[0];
    assign stop_cmd  = wr_ctrl && avs_write_data[1];
    assign busy      = (state != IDLE);
    assign pulsing   = (state == HIGH) || (state == LOW);

    assign timing_ok = (period_r >= MIN_PER) && (high_time_r != 32'd0) &&
                       (high_time_r < period_r);
    assign cfg_ok    = timing_ok && (pulse_num_r != 32'd0);
    assign start_ok  = start_cmd && !busy && cfg_ok;

    assign period_end  = pulsing && (cnt == sh_period - 32'd1);
    assign count_hit   = (sent_r + 32'd1 == pulse_num_r);
    assign move_end    = period_end && (count_hit || stop_req);
    // Reaching the programmed count is a normal end even if a stop was pending.
    assign done_set    = move_end && count_hit;
    assign aborted_set = move_end && !count_hit;
    assign cfg_err_set = start_cmd && !busy && !cfg_ok;

    // Sticky flags: a set in the same cycle as its W1C wins.
    assign w1c         = wr_status ? avs_write_data[3:1] : 3'b000;
    assign done_nxt    = done_set    || (done_r    && !w1c[0]);
    assign aborted_nxt = aborted_set || (aborted_r && !w1c[1]);
    assign cfg_err_nxt = cfg_err_set || (cfg_err_r && !w1c[2]);
    assign irq_en_nxt  = wr_ctrl ? avs_write_data[3] : irq_en_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r    <= '0;
            high_time_r <= '0;
            pulse_num_r <= '0;
            dir_r       <= 1'b0;
            irq_en_r    <= 1'b0;
            stop_req    <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (wr_ctrl && !busy)
                dir_r <= avs_write_data[2];
            irq_en_r <= irq_en_nxt;
            if (wr_period)
                period_r <= avs_write_data;
            if (wr_high)
                high_time_r <= avs_write_data;
            if (wr_pnum && !busy)
                pulse_num_r <= avs_write_data;

            if (move_end)
                stop_req <= 1'b0;
            else if (stop_cmd && (busy || start_ok))
                stop_req <= 1'b1;

            done_r    <= done_nxt;
            aborted_r <= aborted_nxt;
            cfg_err_r <= cfg_err_nxt;
            irq       <= irq_en_nxt && (done_nxt || aborted_nxt);
        end
    end

    // step_out follows the HIGH state one cycle later, so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            setup_cnt <= '0;
            cnt       <= '0;
            sh_period <= '0;
            sh_high   <= '0;
            sent_r    <= '0;
            step_out  <= 1'b0;
            dir_out   <= 1'b0;
        end else begin
            step_out <= (state == HIGH);
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= SETUP;
                        setup_cnt <= '0;
                        sent_r    <= '0;
                        dir_out   <= avs_write_data[2];
                        sh_period <= period_r;
                        sh_high   <= high_time_r;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SETUP_LAST) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else begin
                        setup_cnt <= setup_cnt + 8'd1;
                    end
                end
                HIGH, LOW: begin
                    if (period_end) begin
                        sent_r <= sent_r + 32'd1;
                        cnt    <= '0;
                        if (move_end) begin
                            state <= IDLE;
                        end else begin
                            state <= HIGH;
                            // An inconsistent mid-move update keeps the last good timing.
                            if (timing_ok) begin
                                sh_period <= period_r;
                                sh_high   <= high_time_r;
                            end
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                        if ((state == HIGH) && (cnt == sh_high - 32'd1))
                            state <= LOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STEP_POS_COUNTER_EN
    logic signed [31:0] position;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            position <= '0;
        else if (wr_ctrl && avs_write_data[4])
            position <= '0;
        else if (period_end)
            position <= dir_out ? position + 32'sd1 : position - 32'sd1;
    end

    assign pos_rd = position;
`else
    assign pos_rd = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avs_read_data <= '0;
        end else if (avs_read) begin
            case (avs_address)
                8'h00:   avs_read_data <= {28'd0, irq_en_r, dir_r, 2'b00};
                8'h01:   avs_read_data <= period_r;
                8'h02:   avs_read_data <= high_time_r;
                8'h03:   avs_read_data <= pulse_num_r;
                8'h04:   avs_read_data <= {28'd0, cfg_err_r, aborted_r, done_r, busy};
                8'h05:   avs_read_data <= sent_r;
                8'h06:   avs_read_data <= pos_rd;
                default: avs_read_data <= '0;
            endcase
        end
    end
endmodule
